program_load_sequencer: RTL

//  Boot/run sequencer in front of processor_top. Accepts a tagged word stream (instruction or data),

---
 rtl/program_load_sequencer_if.sv | 41 ++++
 rtl/program_load_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_load_sequencer_if.sv
// program_load_sequencer_if
//   Groups the load-stream handshake and the two memory write ports of the
//   program load sequencer into one bundle.
//   Load stream : s_valid, s_ready, s_tag, s_addr, s_data, s_last
//   Instr write : ins_we, instr_addr, instr
//   Data write  : data_we, data_addr, data
//   master : image source / memory side (drives the stream, observes writes)
//   slave  : the sequencer (accepts the stream, drives the writes)
interface program_load_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic              s_tag;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    logic              ins_we;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr;

    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data;

    modport master (
        output s_valid, s_tag, s_addr, s_data, s_last,
        input  s_ready,
        input  ins_we, instr_addr, instr,
        input  data_we, data_addr, data
    );

    modport slave (
        input  s_valid, s_tag, s_addr, s_data, s_last,
        output s_ready,
        output ins_we, instr_addr, instr,
        output data_we, data_addr, data
    );
endinterface

// File: rtl/program_load_sequencer.sv
// program_load_sequencer
//   Boot/run sequencer in front of processor_top. Accepts a tagged word
//   stream, writes each word into instruction (tag 0) or data (tag 1) memory,
//   holds the core in reset while loading and for RESET_HOLD cycles after
//   the last write, then releases it and counts run cycles until the core
//   reports done or the watchdog expires.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   bus          program_load_sequencer_if.slave: load stream + memory writes
//   clr          synchronous abort/acknowledge, returns to IDLE
//   cpu_rst      reset to processor_top (high in every state except RUN)
//   cpu_done     processor done flag
//   busy         high in LOAD, RELEASE, RUN
//   run_done     high in DONE
//   timeout      high in TIMEOUT
//   cycle_count  RUN cycles elapsed
//   checksum     running XOR of accepted words (optional)
//
// Configuration
//   PLS_CHECKSUM_EN  when defined, checksum is the XOR of s_data over every
//                    accepted beat since the last reset/clr; otherwise 0.
module program_load_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int RESET_HOLD  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    program_load_sequencer_if.slave    bus,
    input  logic                       clr,
    output logic                       cpu_rst,
    input  logic                       cpu_done,
    output logic                       busy,
    output logic                       run_done,
    output logic                       timeout,
    output logic [31:0]                cycle_count,
    output logic [DATA_W-1:0]          checksum
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    state_e            state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       cycle_count_q, cycle_count_d;

    logic              ins_we_q, ins_we_d;
    logic              data_we_q, data_we_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              accept;

    assign accept = bus.s_valid && s_ready_q;

    // Next-state logic. s_ready is registered from the next state so that it
    // reads 0 while reset is held and rises on the first cycle afterwards.
    // The RELEASE counter includes the cycle carrying the final write strobe,
    // so RESET_HOLD full cycles elapse after that strobe before RUN.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    state_d = bus.s_last ? ST_RELEASE : ST_LOAD;
                end
            end
            ST_RELEASE: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(RESET_HOLD)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_done) begin
                    state_d = ST_DONE;
                end else if (cycle_count_q == 32'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (clr) begin
            state_d = ST_IDLE;
        end

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    // Run-cycle counter: cleared on RUN entry, counts every RUN cycle
    // including the one in which cpu_done is seen. The watchdog exit leaves
    // the count at TIMEOUT_CYC-1, the value that triggered it.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (state_q == ST_RELEASE && state_d == ST_RUN) begin
            cycle_count_d = '0;
        end else if (state_q == ST_RUN && state_d != ST_TIMEOUT) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Registered write path: a beat accepted on one edge produces its strobe
    // for exactly the following cycle; address/data hold their last value.
    always_comb begin
        ins_we_d     = accept && !bus.s_tag;
        data_we_d    = accept && bus.s_tag;
        instr_addr_d = instr_addr_q;
        instr_d      = instr_q;
        data_addr_d  = data_addr_q;
        data_d       = data_q;
        if (accept && !bus.s_tag) begin
            instr_addr_d = bus.s_addr;
            instr_d      = bus.s_data;
        end
        if (accept && bus.s_tag) begin
            data_addr_d = bus.s_addr;
            data_d      = bus.s_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            s_ready_q     <= 1'b0;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            ins_we_q      <= 1'b0;
            data_we_q     <= 1'b0;
            instr_addr_q  <= '0;
            instr_q       <= '0;
            data_addr_q   <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            ins_we_q      <= ins_we_d;
            data_we_q     <= data_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_q       <= instr_d;
            data_addr_q   <= data_addr_d;
            data_q        <= data_d;
        end
    end

`ifdef PLS_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Running XOR of accepted words; clr restarts it.
    always_comb begin
        checksum_d = checksum_q;
        if (clr) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ bus.s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign bus.s_ready    = s_ready_q;
    assign bus.ins_we     = ins_we_q;
    assign bus.instr_addr = instr_addr_q;
    assign bus.instr      = instr_q;
    assign bus.data_we    = data_we_q;
    assign bus.data_addr  = data_addr_q;
    assign bus.data       = data_q;

    assign cpu_rst     = (state_q != ST_RUN);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
    assign run_done    = (state_q == ST_DONE);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign cycle_count = cycle_count_q;

endmodule
